// File: rtl/gr_pkg.sv
// rtl/gr_pkg.sv - shared types and constants for the Givens-rotation scheduler
// Contents: FSM state enum, default widths, d_sign group offsets, CORDIC scale K.
package gr_pkg;
   localparam int GR_DW     = 13;
   localparam int GR_NCOL_W = 4;

   // d_sign groups inside the 24-bit job direction word
   localparam int DS_W    = 8;
   localparam int DS0_LSB = 0;
   localparam int DS1_LSB = 8;
   localparam int DS2_LSB = 16;

   // CORDIC gain compensation constant, used by reference models of the engine
   localparam logic [8:0] GR_K = 9'b010011011;

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      S0,
      S1,
      S2
   } gr_state_t;
endpackage

// File: rtl/gr_sched_if.sv
// rtl/gr_sched_if.sv - signal bundle around gr_sched (job, pair in, pair out, engine)
// Modports: slave = scheduler view; master = surrounding datapath (row buffer, sink, engine).
// Option: GR_FIN_CHECK_EN adds fin_err (scheduler output).
interface gr_sched_if
   import gr_pkg::*;
#(
   parameter int DW     = GR_DW,
   parameter int NCOL_W = GR_NCOL_W
) ();
   logic              job_valid;
   logic              job_ready;
   logic [NCOL_W-1:0] job_ncol;
   logic [23:0]       job_dir;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_x;
   logic [DW-1:0]     in_y;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_x;
   logic [DW-1:0]     out_y;
   logic              out_last;
   logic              done;
   logic              gr_en;
   logic [DW-1:0]     gr_x;
   logic [DW-1:0]     gr_y;
   logic [7:0]        gr_d_sign;
   logic [DW-1:0]     gr_xout;
   logic [DW-1:0]     gr_yout;
   logic              gr_fin;
`ifdef GR_FIN_CHECK_EN
   logic              fin_err;
`endif

   modport slave (
`ifdef GR_FIN_CHECK_EN
      output fin_err,
`endif
      input  job_valid, job_ncol, job_dir, in_valid, in_x, in_y, out_ready,
             gr_xout, gr_yout, gr_fin,
      output job_ready, in_ready, out_valid, out_x, out_y, out_last, done,
             gr_en, gr_x, gr_y, gr_d_sign
   );

   modport master (
`ifdef GR_FIN_CHECK_EN
      input  fin_err,
`endif
      output job_valid, job_ncol, job_dir, in_valid, in_x, in_y, out_ready,
             gr_xout, gr_yout, gr_fin,
      input  job_ready, in_ready, out_valid, out_x, out_y, out_last, done,
             gr_en, gr_x, gr_y, gr_d_sign
   );
endinterface

// File: rtl/gr_out_fifo.sv
// rtl/gr_out_fifo.sv - 2-entry result FIFO for gr_sched
// Ports: clk, rst_n (async, active-low); push/push_data write; pop read-advance;
//   pop_data = head entry; count = occupancy 0..2.
// The caller never pushes when full nor pops when empty.
module gr_out_fifo #(
   parameter int W = 27
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic [1:0]   count
);
   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
endmodule

// File: rtl/gr_sched.sv
// rtl/gr_sched.sv - job sequencer for the 3-cycle Givens CORDIC engine
// Purpose: accepts a job (column count + three 8-bit d_sign groups), streams each
//   column pair into the engine as a 3-cycle en burst, and returns the results
//   through a 2-entry FIFO with a last flag; done pulses when the job completes.
// Ports: clk, rst_n (async, active-low); bus (gr_sched_if.slave) with the job,
//   input pair, output pair and engine signals.
// Option: GR_FIN_CHECK_EN adds sticky bus.fin_err (engine fin low at a capture).
module gr_sched
   import gr_pkg::*;
#(
   parameter int DW     = GR_DW,
   parameter int NCOL_W = GR_NCOL_W
) (
   input logic       clk,
   input logic       rst_n,
   gr_sched_if.slave bus
);
   localparam int FW = 2 * DW + 1;

   gr_state_t         state_q, state_d;
   logic [23:0]       dir_q;
   logic [NCOL_W-1:0] rem_q;
   logic [DW-1:0]     x_q, y_q;
   logic              pend_q, done_q, done_set;
   logic              in_ready, gr_en, busy, rem_ok, start;
   logic [7:0]        d_sign;
   logic [1:0]        fifo_count;
   logic [2:0]        credits;
   logic [FW-1:0]     fifo_out;
   logic              out_valid, pop;

   assign busy    = (state_q == S0) || (state_q == S1) || (state_q == S2);
   // Result slots already committed: stored results, the result being captured now,
   // and the burst in progress. Starting only below 2 keeps the FIFO from overflowing.
   assign credits = {1'b0, fifo_count} + {2'b00, pend_q} + {2'b00, busy};
   // In S2 the current pair is already counted as done.
   assign rem_ok  = (state_q == S2) ? (rem_q > NCOL_W'(1)) : (rem_q != '0);
   assign start   = bus.in_valid && rem_ok && (credits < 3'd2);

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      done_set = 1'b0;
      gr_en    = 1'b0;
      d_sign   = '0;
      case (state_q)
         IDLE: begin
            if (bus.job_valid) begin
               if (bus.job_ncol == '0) done_set = 1'b1;
               else                    state_d  = GAP;
            end
         end
         GAP: begin
            if (start) begin
               in_ready = 1'b1;
               state_d  = S0;
            end else if ((rem_q == '0) && !pend_q) begin
               done_set = 1'b1;
               state_d  = IDLE;
            end
         end
         S0: begin
            gr_en   = 1'b1;
            d_sign  = dir_q[DS0_LSB +: DS_W];
            state_d = S1;
         end
         S1: begin
            gr_en   = 1'b1;
            d_sign  = dir_q[DS1_LSB +: DS_W];
            state_d = S2;
         end
         S2: begin
            gr_en  = 1'b1;
            d_sign = dir_q[DS2_LSB +: DS_W];
            if (start) begin
               in_ready = 1'b1;
               state_d  = S0;
            end else begin
               state_d  = GAP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dir_q   <= '0;
         rem_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_set;
         // Engine result is valid the cycle after the third en cycle.
         pend_q  <= (state_q == S2);
         if ((state_q == IDLE) && bus.job_valid) begin
            dir_q <= bus.job_dir;
            rem_q <= bus.job_ncol;
         end else if (state_q == S2) begin
            rem_q <= rem_q - NCOL_W'(1);
         end
         if (in_ready) begin
            x_q <= bus.in_x;
            y_q <= bus.in_y;
         end
      end
   end

   // Capture is keyed on pend: gr_fin stays high between results.
   // rem_q has already been decremented, so zero marks the job's final pair.
   gr_out_fifo #(.W(FW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (pend_q),
      .push_data ({(rem_q == '0), bus.gr_yout, bus.gr_xout}),
      .pop       (pop),
      .pop_data  (fifo_out),
      .count     (fifo_count)
   );

   assign out_valid = (fifo_count != 2'd0);
   assign pop       = out_valid && bus.out_ready;

   assign bus.job_ready = (state_q == IDLE);
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign {bus.out_last, bus.out_y, bus.out_x} = fifo_out;
   assign bus.done      = done_q;
   assign bus.gr_en     = gr_en;
   assign bus.gr_x      = x_q;
   assign bus.gr_y      = y_q;
   assign bus.gr_d_sign = d_sign;

`ifdef GR_FIN_CHECK_EN
   logic fin_err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      fin_err_q <= 1'b0;
      else if (pend_q && !bus.gr_fin)  fin_err_q <= 1'b1;
   end
   assign bus.fin_err = fin_err_q;
`else
   logic unused_gr_fin;
   assign unused_gr_fin = bus.gr_fin;
`endif
endmodule

// File: tb/tb_gr_sched.sv
// tb/tb_gr_sched.sv - directed self-checking bench for gr_sched
module tb_gr_sched;
   localparam int DW     = 13;
   localparam int NCOL_W = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gr_sched_if #(.DW(DW), .NCOL_W(NCOL_W)) bus ();
   gr_sched #(.DW(DW), .NCOL_W(NCOL_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic          last;
      logic [DW-1:0] y;
      logic [DW-1:0] x;
   } res_t;

   int n_vec = 0;
   int n_err = 0;

   res_t            exp_q[$];
   logic [2*DW-1:0] eng_q[$];
   logic [7:0]      ds_log[$];
   logic [DW-1:0]   px[16];
   logic [DW-1:0]   py[16];
   int              np;
   logic [23:0]     cur_dir;
   bit              fin_kill;
   res_t            last_out;
   int cyc = 0;
   int accepted, delivered, done_cnt, en_cycles, en_run, max_run, first_acc, first_ov;
   bit ov_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Compare process: output stream against the scoreboard, plus stream-level properties.
   initial begin : monitor
      res_t e;
      ov_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ov_prev = 1'b0;
            en_run  = 0;
            continue;
         end
         if (bus.done) done_cnt++;
         if (bus.gr_en) begin
            en_cycles++;
            en_run++;
            if (en_run > max_run) max_run = en_run;
            ds_log.push_back(bus.gr_d_sign);
         end else begin
            en_run = 0;
         end
         if (bus.in_valid && bus.in_ready) begin
            accepted++;
            if (first_acc < 0) first_acc = cyc + 1;
            chk("outstanding_le_2", 32'((accepted - delivered) <= 2), 32'd1);
         end
         if (bus.out_valid && !ov_prev && first_ov < 0) first_ov = cyc;
         ov_prev = bus.out_valid;
         if (bus.out_valid && bus.out_ready) begin
            chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_x", 32'(bus.out_x), 32'(e.x));
               chk("out_y", 32'(bus.out_y), 32'(e.y));
               chk("out_last", 32'(bus.out_last), 32'(e.last));
            end
            last_out = {bus.out_last, bus.out_y, bus.out_x};
            delivered++;
         end
      end
   end

   // Engine model: checks each en burst and returns (x-y, x+y) after the third cycle.
   initial begin : engine
      int              en_cnt;
      logic [2*DW-1:0] cur;
      logic [DW-1:0]   rx, ry;
      bit              apply;
      en_cnt = 0;
      apply  = 1'b0;
      cur    = '0;
      bus.gr_xout = '0;
      bus.gr_yout = '0;
      bus.gr_fin  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            en_cnt = 0;
            continue;
         end
         if (bus.gr_en) begin
            if (en_cnt == 0) begin
               chk("burst_expected", 32'(eng_q.size() != 0), 32'd1);
               if (eng_q.size() != 0) cur = eng_q.pop_front();
            end
            chk("gr_x", 32'(bus.gr_x), 32'(cur[DW-1:0]));
            chk("gr_y", 32'(bus.gr_y), 32'(cur[2*DW-1:DW]));
            chk("gr_d_sign", 32'(bus.gr_d_sign), 32'(cur_dir[8*en_cnt +: 8]));
            if (en_cnt == 2) begin
               en_cnt = 0;
               rx     = cur[DW-1:0] - cur[2*DW-1:DW];
               ry     = cur[DW-1:0] + cur[2*DW-1:DW];
               apply  = 1'b1;
            end else begin
               en_cnt++;
            end
         end else begin
            if (en_cnt != 0) chk("burst_len", 32'(en_cnt), 32'd3);
            en_cnt = 0;
         end
         if (apply) begin
            @(posedge clk);
            #1;
            bus.gr_xout = rx;
            bus.gr_yout = ry;
            bus.gr_fin  = !fin_kill;
            apply       = 1'b0;
         end
      end
   end

   task automatic begin_test();
      done_cnt  = 0;
      en_cycles = 0;
      max_run   = 0;
      accepted  = 0;
      delivered = 0;
      first_acc = -1;
      first_ov  = -1;
      np        = 0;
      ds_log.delete();
   endtask

   task automatic add_pair(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic last);
      res_t r;
      px[np] = x;
      py[np] = y;
      np++;
      eng_q.push_back({y, x});
      r.last = last;
      r.x    = x - y;
      r.y    = x + y;
      exp_q.push_back(r);
   endtask

   task automatic plan(input int n, input int seed);
      for (int i = 0; i < n; i++)
         add_pair(DW'(seed + 211 * i), DW'(3 * seed - 97 * i), (i == n - 1));
   endtask

   task automatic issue_job(input logic [NCOL_W-1:0] ncol, input logic [23:0] dir);
      int t = 0;
      while (!bus.job_ready && t < 200) begin
         tick();
         t++;
      end
      chk("job_ready_wait", 32'(bus.job_ready), 32'd1);
      cur_dir       = dir;
      bus.job_valid = 1'b1;
      bus.job_ncol  = ncol;
      bus.job_dir   = dir;
      tick();
      bus.job_valid = 1'b0;
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         bit acc;
         bus.in_valid = 1'b1;
         bus.in_x     = px[i];
         bus.in_y     = py[i];
         t   = 0;
         acc = 1'b0;
         while (!acc && t < 400) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            t++;
         end
         chk("accept_in_time", 32'(acc), 32'd1);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int done_exp);
      int t = 0;
      while ((exp_q.size() != 0 || done_cnt < done_exp) && t < 400) begin
         tick();
         t++;
      end
      chk("drain_in_time", 32'(t < 400), 32'd1);
      repeat (3) tick();
   endtask

   initial begin : watchdog
      #200000;
      n_err++;
      $display("FAIL watchdog: time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : main
      bus.job_valid = 1'b0;
      bus.job_ncol  = '0;
      bus.job_dir   = '0;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.out_ready = 1'b0;
      fin_kill      = 1'b0;
      cur_dir       = '0;
      begin_test();
      repeat (3) tick();

      // reset values
      chk("rst_job_ready", 32'(bus.job_ready), 32'd1);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_x", 32'(bus.out_x), 32'd0);
      chk("rst_out_y", 32'(bus.out_y), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_gr_en", 32'(bus.gr_en), 32'd0);
      chk("rst_gr_x", 32'(bus.gr_x), 32'd0);
      chk("rst_gr_y", 32'(bus.gr_y), 32'd0);
      chk("rst_gr_d_sign", 32'(bus.gr_d_sign), 32'd0);
`ifdef GR_FIN_CHECK_EN
      chk("rst_fin_err", 32'(bus.fin_err), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // T1: single pair (100,50), dir 55AA55
      begin_test();
      bus.out_ready = 1'b1;
      add_pair(13'd100, 13'd50, 1'b1);
      issue_job(4'd1, 24'h55AA55);
      feed(1);
      drain(1);
      chk("t1_en_cycles", 32'(en_cycles), 32'd3);
      chk("t1_ds0", 32'(ds_log.size() > 0 ? ds_log[0] : 8'h00), 32'h55);
      chk("t1_ds1", 32'(ds_log.size() > 1 ? ds_log[1] : 8'h00), 32'hAA);
      chk("t1_ds2", 32'(ds_log.size() > 2 ? ds_log[2] : 8'h00), 32'h55);
      chk("t1_latency", 32'(first_ov - first_acc), 32'd4);
      chk("t1_out_x", 32'(last_out.x), 32'd50);
      chk("t1_out_y", 32'(last_out.y), 32'd150);
      chk("t1_out_last", 32'(last_out.last), 32'd1);
      chk("t1_done", 32'(done_cnt), 32'd1);
      chk("t1_delivered", 32'(delivered), 32'd1);

      // T2: four pairs back-to-back with in_valid held high
      begin_test();
      plan(4, 300);
      issue_job(4'd4, 24'hC33C0F);
      feed(4);
      drain(1);
      chk("t2_en_cycles", 32'(en_cycles), 32'd12);
      chk("t2_en_run", 32'(max_run), 32'd12);
      chk("t2_delivered", 32'(delivered), 32'd4);
      chk("t2_last_flag", 32'(last_out.last), 32'd1);
      chk("t2_done", 32'(done_cnt), 32'd1);

      // T3: out_ready low stalls after two pairs; stray job_valid ignored
      begin_test();
      bus.out_ready = 1'b0;
      plan(3, 1234);
      issue_job(4'd3, 24'h817E18);
      fork
         feed(3);
         begin
            repeat (40) tick();
            chk("t3_accepted_stalled", 32'(accepted), 32'd2);
            bus.job_valid = 1'b1;
            bus.job_ncol  = '0;
            tick();
            bus.job_valid = 1'b0;
            repeat (5) tick();
            chk("t3_accepted_still", 32'(accepted), 32'd2);
            chk("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
            chk("t3_out_valid_held", 32'(bus.out_valid), 32'd1);
            bus.out_ready = 1'b1;
         end
      join
      drain(1);
      chk("t3_delivered", 32'(delivered), 32'd3);
      chk("t3_done", 32'(done_cnt), 32'd1);
      chk("t3_last_flag", 32'(last_out.last), 32'd1);

      // T4: empty job
      begin_test();
      issue_job(4'd0, 24'hFFFFFF);
      repeat (6) tick();
      chk("t4_done", 32'(done_cnt), 32'd1);
      chk("t4_en_cycles", 32'(en_cycles), 32'd0);
      chk("t4_delivered", 32'(delivered), 32'd0);
      chk("t4_job_ready", 32'(bus.job_ready), 32'd1);

      // T5: reset during S1 of the second burst, one result waiting in the FIFO
      begin_test();
      bus.out_ready = 1'b0;
      plan(2, 77);
      issue_job(4'd2, 24'h123456);
      feed(2);
      tick();
      chk("t5_pre_gr_en", 32'(bus.gr_en), 32'd1);
      chk("t5_pre_d_sign_s1", 32'(bus.gr_d_sign), 32'h34);
      chk("t5_pre_out_valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_gr_en", 32'(bus.gr_en), 32'd0);
      chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t5_rst_job_ready", 32'(bus.job_ready), 32'd1);
      chk("t5_rst_d_sign", 32'(bus.gr_d_sign), 32'd0);
      exp_q.delete();
      eng_q.delete();
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("t5_post_job_ready", 32'(bus.job_ready), 32'd1);
      chk("t5_post_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t5_post_gr_en", 32'(bus.gr_en), 32'd0);
      chk("t5_post_in_ready", 32'(bus.in_ready), 32'd0);

`ifdef GR_FIN_CHECK_EN
      // T6: engine fin low at a capture sets fin_err until reset
      begin_test();
      chk("t6_fin_err_clear", 32'(bus.fin_err), 32'd0);
      bus.out_ready = 1'b1;
      fin_kill      = 1'b1;
      plan(1, 500);
      issue_job(4'd1, 24'hA5A5A5);
      feed(1);
      drain(1);
      fin_kill = 1'b0;
      chk("t6_fin_err_set", 32'(bus.fin_err), 32'd1);
      begin_test();
      plan(2, 9);
      issue_job(4'd2, 24'h0102F0);
      feed(2);
      drain(1);
      chk("t6_fin_err_sticky", 32'(bus.fin_err), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_fin_err_reset", 32'(bus.fin_err), 32'd0);
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
